player_mover: RTL and testbench

PLAYER_MOVER -- requirements
Module: player_mover

---
 rtl/maze_pkg.sv | 24 ++
 rtl/step_timer.sv | 27 ++
 rtl/player_mover.sv | 163 ++++++++++++++++
 tb/tb_player_mover.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze player logic: direction encoding, mover
// FSM states and default board bounds.
package maze_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUND,
        ST_QUERY,
        ST_COMMIT,
        ST_COOL
    } mover_state_t;

    localparam int BOARD_X_MAX = 159;
    localparam int BOARD_Y_MAX = 119;
    localparam int TIMER_W     = 16;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module step_timer
    import maze_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/player_mover.sv
// Moves the player one cell per accepted request after bounds checking and a
// legality query to the barrier checker, then enforces a cooldown.
module player_mover
    import maze_pkg::*;
#(
    parameter int X_MAX       = BOARD_X_MAX,
    parameter int Y_MAX       = BOARD_Y_MAX,
    parameter int X_START     = 0,
    parameter int Y_START     = 0,
    parameter int STEP_DELAY  = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        dir_valid,
    input  logic [1:0]  dir,
    output logic        dir_ready,
    output logic        check_req,
    output logic [7:0]  cand_x,
    output logic [6:0]  cand_y,
    input  logic        check_ack,
    input  logic        check_legal,
    output logic [7:0]  pos_x,
    output logic [6:0]  pos_y,
    output logic        done_change_position,
    output logic [15:0] move_count,
    output logic        timeout_err
);

    localparam logic [7:0] X_LIM  = 8'(X_MAX);
    localparam logic [6:0] Y_LIM  = 7'(Y_MAX);
    localparam logic [7:0] X_INIT = 8'(X_START);
    localparam logic [6:0] Y_INIT = 7'(Y_START);
    localparam logic [TIMER_W-1:0] ACK_LOAD  = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] COOL_LOAD = (STEP_DELAY > 0) ? TIMER_W'(STEP_DELAY - 1) : '0;

    mover_state_t       state;
    dir_t               dir_q;
    logic [7:0]         next_x;
    logic [6:0]         next_y;
    logic               in_bounds;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic [TIMER_W-1:0] timer_count;
    logic               timer_done;

    // Candidate cell one step from the current position; edges never wrap.
    always_comb begin
        next_x    = pos_x;
        next_y    = pos_y;
        in_bounds = 1'b1;
        case (dir_q)
            DIR_UP: begin
                if (pos_y == 7'd0) in_bounds = 1'b0;
                else               next_y    = pos_y - 7'd1;
            end
            DIR_DOWN: begin
                if (pos_y >= Y_LIM) in_bounds = 1'b0;
                else                next_y    = pos_y + 7'd1;
            end
            DIR_LEFT: begin
                if (pos_x == 8'd0) in_bounds = 1'b0;
                else               next_x    = pos_x - 8'd1;
            end
            DIR_RIGHT: begin
                if (pos_x >= X_LIM) in_bounds = 1'b0;
                else                next_x    = pos_x + 8'd1;
            end
        endcase
    end

    // The ack window and the cooldown never overlap, so one timer serves both.
    assign timer_load  = (state == ST_BOUND && in_bounds) || (state == ST_COMMIT);
    assign timer_value = (state == ST_COMMIT) ? COOL_LOAD : ACK_LOAD;

    step_timer #(.W(TIMER_W)) u_timer (
        .clock      (clock),
        .resetn     (resetn),
        .load       (timer_load),
        .load_value (timer_value),
        .count      (timer_count),
        .done       (timer_done)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state                <= ST_IDLE;
            dir_q                <= DIR_UP;
            pos_x                <= X_INIT;
            pos_y                <= Y_INIT;
            cand_x               <= '0;
            cand_y               <= '0;
            dir_ready            <= 1'b1;
            check_req            <= 1'b0;
            done_change_position <= 1'b0;
            move_count           <= '0;
            timeout_err          <= 1'b0;
        end else begin
            done_change_position <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dir_valid) begin
                        dir_q     <= dir_t'(dir);
                        dir_ready <= 1'b0;
                        state     <= ST_BOUND;
                    end
                end
                ST_BOUND: begin
                    if (in_bounds) begin
                        cand_x    <= next_x;
                        cand_y    <= next_y;
                        check_req <= 1'b1;
                        state     <= ST_QUERY;
                    end else begin
                        dir_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                // An ack in the last window cycle takes priority over the timeout.
                ST_QUERY: begin
                    if (check_ack) begin
                        check_req <= 1'b0;
                        if (check_legal) begin
                            state <= ST_COMMIT;
                        end else begin
                            dir_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end else if (timer_done) begin
                        check_req   <= 1'b0;
                        timeout_err <= 1'b1;
                        dir_ready   <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    pos_x                <= cand_x;
                    pos_y                <= cand_y;
                    move_count           <= move_count + 16'd1;
                    done_change_position <= 1'b1;
                    if (STEP_DELAY == 0) begin
                        dir_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        state <= ST_COOL;
                    end
                end
                ST_COOL: begin
                    if (timer_done) begin
                        dir_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    check_req <= 1'b0;
                    dir_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_mover.sv
// Bench for player_mover: directed cases with literal expectations, then
// random traffic checked every cycle against a timeline model of the mover.
module tb_player_mover;
    import maze_pkg::*;

    localparam int XM  = 7;
    localparam int YM  = 5;
    localparam int SD  = 4;
    localparam int AT  = 16;
    localparam int INF = 32'h3fff_ffff;

    logic        clock = 1'b0;
    logic        resetn;
    logic        dir_valid;
    logic [1:0]  dir;
    logic        dir_ready;
    logic        check_req;
    logic [7:0]  cand_x;
    logic [6:0]  cand_y;
    logic        check_ack;
    logic        check_legal;
    logic [7:0]  pos_x;
    logic [6:0]  pos_y;
    logic        done_change_position;
    logic [15:0] move_count;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;
    bit cmpEn    = 1'b0;

    always #5 clock = ~clock;

    player_mover #(
        .X_MAX(XM), .Y_MAX(YM), .X_START(0), .Y_START(0),
        .STEP_DELAY(SD), .ACK_TIMEOUT(AT)
    ) dut (
        .clock                (clock),
        .resetn               (resetn),
        .dir_valid            (dir_valid),
        .dir                  (dir),
        .dir_ready            (dir_ready),
        .check_req            (check_req),
        .cand_x               (cand_x),
        .cand_y               (cand_y),
        .check_ack            (check_ack),
        .check_legal          (check_legal),
        .pos_x                (pos_x),
        .pos_y                (pos_y),
        .done_change_position (done_change_position),
        .move_count           (move_count),
        .timeout_err          (timeout_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: tracks the edge index at which each phase of a move
    // resolves, rather than a state register.
    int   mN, mReadyAt, mBoundAt, mCommitAt, mQStart;
    bit   mBusy, mQOpen, mInb, mDone, mTerr;
    int   mPosX, mPosY, mCandX, mCandY, mTgtX, mTgtY;
    logic [15:0] mCount;

    task automatic modelReset();
        mN = 0; mReadyAt = 0; mBoundAt = -1; mCommitAt = -1; mQStart = 0;
        mBusy = 0; mQOpen = 0; mInb = 0; mDone = 0; mTerr = 0;
        mPosX = 0; mPosY = 0; mCandX = 0; mCandY = 0; mTgtX = 0; mTgtY = 0;
        mCount = 16'd0;
    endtask

    task automatic modelStep();
        mN++;
        mDone = 0;
        if (!mBusy) begin
            if (dir_valid) begin
                mBusy = 1; mReadyAt = INF; mBoundAt = mN + 1;
                mTgtX = mPosX; mTgtY = mPosY;
                case (dir)
                    2'd0: mTgtY = mPosY - 1;
                    2'd1: mTgtY = mPosY + 1;
                    2'd2: mTgtX = mPosX - 1;
                    default: mTgtX = mPosX + 1;
                endcase
                mInb = (mTgtX >= 0) && (mTgtX <= XM) && (mTgtY >= 0) && (mTgtY <= YM);
            end
        end else if (mN == mBoundAt) begin
            if (!mInb) mReadyAt = mN;
            else begin
                mCandX = mTgtX; mCandY = mTgtY; mQOpen = 1; mQStart = mN;
            end
        end else if (mQOpen) begin
            if (check_ack) begin
                mQOpen = 0;
                if (check_legal) mCommitAt = mN + 1;
                else             mReadyAt  = mN;
            end else if (mN - mQStart == AT) begin
                mQOpen = 0; mTerr = 1; mReadyAt = mN;
            end
        end else if (mN == mCommitAt) begin
            mPosX = mTgtX; mPosY = mTgtY; mCount = mCount + 16'd1;
            mDone = 1; mReadyAt = mN + SD;
        end
        if (mBusy && mN >= mReadyAt) mBusy = 0;
    endtask

    always @(posedge clock or negedge resetn) begin
        if (!resetn) modelReset();
        else         modelStep();
    end

    always @(negedge clock) begin
        if (cmpEn) begin
            checkOutput("dir_ready",   32'(dir_ready),            32'(!mBusy));
            checkOutput("check_req",   32'(check_req),            32'(mQOpen));
            checkOutput("cand_x",      32'(cand_x),               mCandX);
            checkOutput("cand_y",      32'(cand_y),               mCandY);
            checkOutput("pos_x",       32'(pos_x),                mPosX);
            checkOutput("pos_y",       32'(pos_y),                mPosY);
            checkOutput("done",        32'(done_change_position), 32'(mDone));
            checkOutput("move_count",  32'(move_count),           32'(mCount));
            checkOutput("timeout_err", 32'(timeout_err),          32'(mTerr));
        end
    end

    task automatic applyStimulus(input bit v, input logic [1:0] d, input bit ack, input bit legal);
        dir_valid   = v;
        dir         = d;
        check_ack   = ack;
        check_legal = legal;
        @(negedge clock);
    endtask

    task automatic pulseReset();
        dir_valid = 1'b0; check_ack = 1'b0; check_legal = 1'b0;
        #2 resetn = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(dir_ready), 1);
        checkOutput("rst_req",   32'(check_req), 0);
        checkOutput("rst_pos_x", 32'(pos_x), 0);
        checkOutput("rst_pos_y", 32'(pos_y), 0);
        checkOutput("rst_cand",  32'({cand_x, cand_y}), 0);
        checkOutput("rst_done",  32'(done_change_position), 0);
        checkOutput("rst_count", 32'(move_count), 0);
        checkOutput("rst_terr",  32'(timeout_err), 0);
        @(negedge clock);
        #2 resetn = 1'b1;
        @(negedge clock);
        checkOutput("rel_ready", 32'(dir_ready), 1);
    endtask

    task automatic doMove(input logic [1:0] d, input bit legal);
        bit settled = 1'b0;
        applyStimulus(1'b1, d, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (dir_ready) begin
                settled = 1'b1;
                break;
            end
            applyStimulus(1'b0, 2'd0, check_req, legal);
        end
        if (!settled) checkOutput("move_settle", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lowCycles;
        int ackPct;
        resetn = 1'b0;
        dir_valid = 1'b0; dir = 2'd0; check_ack = 1'b0; check_legal = 1'b0;
        modelReset();
        cmpEn = 1'b1;
        repeat (2) @(negedge clock);
        #2 resetn = 1'b1;
        @(negedge clock);
        checkOutput("init_ready", 32'(dir_ready), 1);
        checkOutput("init_pos",   32'({pos_x, pos_y}), 0);

        $display("[TB] left at origin is rejected in bounds check");
        applyStimulus(1'b1, DIR_LEFT, 1'b0, 1'b0);
        checkOutput("oob_ready_lo", 32'(dir_ready), 0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("oob_ready_hi", 32'(dir_ready), 1);
        checkOutput("oob_req", 32'(check_req), 0);
        checkOutput("oob_pos_x", 32'(pos_x), 0);

        $display("[TB] right with immediate legal ack");
        applyStimulus(1'b1, DIR_RIGHT, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("t1_req", 32'(check_req), 1);
        checkOutput("t1_cand_x", 32'(cand_x), 1);
        checkOutput("t1_cand_y", 32'(cand_y), 0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
        checkOutput("t1_pos_pre", 32'(pos_x), 0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("t1_pos_x", 32'(pos_x), 1);
        checkOutput("t1_pos_y", 32'(pos_y), 0);
        checkOutput("t1_done", 32'(done_change_position), 1);
        checkOutput("t1_count", 32'(move_count), 1);
        lowCycles = 0;
        for (int i = 0; i < 12; i++) begin
            if (dir_ready) break;
            lowCycles++;
            applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
            if (i == 0) checkOutput("t1_done_width", 32'(done_change_position), 0);
        end
        checkOutput("t1_cool_cycles", lowCycles, 4);

        $display("[TB] checker says illegal");
        applyStimulus(1'b1, DIR_DOWN, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        checkOutput("ill_ready", 32'(dir_ready), 1);
        checkOutput("ill_pos_y", 32'(pos_y), 0);
        checkOutput("ill_count", 32'(move_count), 1);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("ill_done", 32'(done_change_position), 0);

        $display("[TB] ack in last window cycle commits");
        applyStimulus(1'b1, DIR_DOWN, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        repeat (15) applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("a16_req", 32'(check_req), 1);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
        checkOutput("a16_terr", 32'(timeout_err), 0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("a16_pos_y", 32'(pos_y), 1);
        checkOutput("a16_count", 32'(move_count), 2);
        repeat (SD) applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("a16_ready", 32'(dir_ready), 1);

        $display("[TB] checker timeout");
        applyStimulus(1'b1, DIR_RIGHT, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        repeat (15) applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("to_terr_pre", 32'(timeout_err), 0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("to_terr", 32'(timeout_err), 1);
        checkOutput("to_ready", 32'(dir_ready), 1);
        checkOutput("to_pos_x", 32'(pos_x), 1);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
        checkOutput("stray_ack_pos", 32'(pos_x), 1);
        checkOutput("stray_ack_count", 32'(move_count), 2);

        $display("[TB] far edges");
        repeat (6) doMove(DIR_RIGHT, 1'b1);
        repeat (4) doMove(DIR_DOWN, 1'b1);
        checkOutput("edge_pos", 32'({pos_x, pos_y}), 32'({8'd7, 7'd5}));
        applyStimulus(1'b1, DIR_RIGHT, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
        checkOutput("xmax_req", 32'(check_req), 0);
        checkOutput("xmax_ready", 32'(dir_ready), 1);
        checkOutput("xmax_pos_x", 32'(pos_x), 7);
        repeat (2) doMove(DIR_LEFT, 1'b1);
        applyStimulus(1'b1, DIR_DOWN, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
        checkOutput("ymax_req", 32'(check_req), 0);
        checkOutput("ymax_pos", 32'({pos_x, pos_y}), 32'({8'd5, 7'd5}));
        checkOutput("terr_sticky", 32'(timeout_err), 1);

        $display("[TB] reset during cooldown");
        applyStimulus(1'b1, DIR_UP, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("cool_done", 32'(done_change_position), 1);
        pulseReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
            checkOutput("cool_rst_done", 32'(done_change_position), 0);
        end

        $display("[TB] reset during query");
        applyStimulus(1'b1, DIR_RIGHT, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("q_req", 32'(check_req), 1);
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
            checkOutput("q_rst_done", 32'(done_change_position), 0);
            checkOutput("q_rst_pos", 32'(pos_x), 0);
        end

        $display("[TB] random traffic");
        ackPct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ackPct = 0;
                    1:       ackPct = 15;
                    default: ackPct = 70;
                endcase
            end
            if (c == 1500) pulseReset();
            applyStimulus(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          (int'($urandom_range(0, 99)) < ackPct), ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
